// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches words from instruction memory and
// presents them for one execute cycle, then computes the next fetch address.
module instr_fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic [31:0] imemload,
  output logic        instr_valid,
  output logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic        jal,
  input  logic        jr,
  input  logic        beq,
  input  logic        bne,
  input  logic        zero,
  input  logic [31:0] rdat1,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_r, next_state_s;
  logic [31:0] pc_r;
  logic [31:0] imemload_r;
  logic [31:0] count_r;
  logic [31:0] next_pc_s;
  logic        iren_s, valid_s, load_s, retire_s, pc_load_s;

  // Next-PC selection; jr outranks jumps, which outrank branches.
  function automatic logic [31:0] calc_next_pc(
    input logic [31:0] seq_pc,
    input logic [31:0] instr,
    input logic [31:0] reg_target,
    input logic        f_jump,
    input logic        f_jal,
    input logic        f_jr,
    input logic        f_beq,
    input logic        f_bne,
    input logic        f_zero
  );
    logic [31:0] result;
    if (f_jr) begin
      result = {reg_target[31:2], 2'b00};
    end else if (f_jump || f_jal) begin
      result = {seq_pc[31:28], instr[25:0], 2'b00};
    end else if ((f_beq && f_zero) || (f_bne && !f_zero)) begin
      result = seq_pc + {{14{instr[15]}}, instr[15:0], 2'b00};
    end else begin
      result = seq_pc;
    end
    return result;
  endfunction

  assign pc_plus4 = pc_r + 32'd4;
  assign next_pc_s = calc_next_pc(pc_plus4, imemload_r, rdat1, jump, jal, jr, beq, bne, zero);

  // Next-state and datapath enables.
  always_comb begin
    next_state_s = state_r;
    iren_s       = 1'b0;
    valid_s      = 1'b0;
    load_s       = 1'b0;
    retire_s     = 1'b0;
    pc_load_s    = 1'b0;
    case (state_r)
      FETCH: begin
        iren_s = 1'b1;
        if (ihit) begin
          load_s       = 1'b1;
          next_state_s = EXEC;
        end else begin
          next_state_s = FETCH;
        end
      end
      EXEC: begin
        valid_s  = 1'b1;
        retire_s = 1'b1;
        if (halt) begin
          next_state_s = HALTED;
        end else begin
          pc_load_s    = 1'b1;
          next_state_s = FETCH;
        end
      end
      HALTED: begin
        next_state_s = HALTED;
      end
      default: begin
        next_state_s = FETCH;
      end
    endcase
  end

  // State, PC, latched instruction and retire counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= FETCH;
      pc_r       <= {PC_INIT[31:2], 2'b00};
      imemload_r <= 32'h0000_0000;
      count_r    <= 32'h0000_0000;
    end else begin
      state_r <= next_state_s;
      if (load_s) begin
        imemload_r <= iload;
      end
      if (pc_load_s) begin
        pc_r <= next_pc_s;
      end
      if (retire_s) begin
        count_r <= count_r + 32'd1;
      end
    end
  end

  // Request and valid are suppressed during reset so an in-flight fetch is abandoned.
  assign iREN        = iren_s & ~RST;
  assign instr_valid = valid_s & ~RST;
  assign iaddr       = pc_r;
  assign imemload    = imemload_r;
  assign halted      = (state_r == HALTED);
  assign instr_count = count_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized and directed bench for instr_fetch_unit against a behavioural PC model.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic [31:0] imemload;
  logic        instr_valid;
  logic [31:0] pc_plus4;
  logic        jump, jal, jr, beq, bne, zero, halt;
  logic [31:0] rdat1;
  logic        halted;
  logic [31:0] instr_count;

  int total = 0;
  int bad = 0;

  logic [31:0] mpc, mcount, mword;
  logic        mhalted;

  always #5 CLK = ~CLK;

  instr_fetch_unit dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .imemload(imemload), .instr_valid(instr_valid), .pc_plus4(pc_plus4),
    .jump(jump), .jal(jal), .jr(jr), .beq(beq), .bne(bne), .zero(zero),
    .rdat1(rdat1), .halt(halt), .halted(halted), .instr_count(instr_count)
  );

  // Reference next-PC from the architectural rules, using plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] word,
                                           input logic [31:0] r1, input logic j, input logic jl,
                                           input logic jrr, input logic bq, input logic bn,
                                           input logic z);
    logic [31:0] seq;
    int off;
    seq = pc + 32'd4;
    if (jrr) return r1 - (r1 % 32'd4);
    if (j || jl) return (seq & 32'hF000_0000) + (word % 32'h0400_0000) * 32'd4;
    if ((bq && z) || (bn && !z)) begin
      off = $signed(word[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_ctrl();
    jump = 1'b0; jal = 1'b0; jr = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0; halt = 1'b0;
    rdat1 = 32'h0000_0000;
  endtask

  task automatic do_reset();
    RST = 1'b1; ihit = 1'b0; iload = 32'h0000_0000; clear_ctrl();
    tick();
    RST = 1'b0;
    #1;
    mpc = 32'h0000_0000; mcount = 32'h0000_0000; mhalted = 1'b0; mword = 32'h0000_0000;
  endtask

  // FETCH phase with 'waits' stall cycles, then EXEC-phase output checks.
  task automatic fetch(input int waits, input logic [31:0] word);
    for (int i = 0; i < waits; i++) begin
      ihit = 1'b0; #1;
      total++; if (iREN !== 1'b1) begin bad++; $display("FAIL fetch_iren got=%b exp=1", iREN); end
      total++; if (iaddr !== mpc) begin bad++; $display("FAIL fetch_iaddr got=%h exp=%h", iaddr, mpc); end
      tick();
    end
    ihit = 1'b1; iload = word; #1;
    total++; if (iREN !== 1'b1) begin bad++; $display("FAIL hit_iren got=%b exp=1", iREN); end
    total++; if (iaddr !== mpc) begin bad++; $display("FAIL hit_iaddr got=%h exp=%h", iaddr, mpc); end
    tick();
    ihit = 1'b0; iload = $urandom; #1;
    mword = word;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL exec_valid got=%b exp=1", instr_valid); end
    total++; if (imemload !== word) begin bad++; $display("FAIL exec_imemload got=%h exp=%h", imemload, word); end
    total++; if (iREN !== 1'b0) begin bad++; $display("FAIL exec_iren got=%b exp=0", iREN); end
    total++; if (pc_plus4 !== mpc + 32'd4) begin bad++; $display("FAIL exec_pcplus4 got=%h exp=%h", pc_plus4, mpc + 32'd4); end
  endtask

  // EXEC cycle: drive controls, advance, compare against the model.
  task automatic exec(input logic j, input logic jl, input logic jrr, input logic bq,
                      input logic bn, input logic z, input logic h, input logic [31:0] r1);
    logic [31:0] exp_pc;
    jump = j; jal = jl; jr = jrr; beq = bq; bne = bn; zero = z; halt = h; rdat1 = r1;
    exp_pc = h ? mpc : ref_next(mpc, mword, r1, j, jl, jrr, bq, bn, z);
    tick();
    clear_ctrl(); #1;
    mcount = mcount + 32'd1;
    if (h) mhalted = 1'b1;
    mpc = exp_pc;
    total++; if (iaddr !== mpc) begin bad++; $display("FAIL next_iaddr got=%h exp=%h", iaddr, mpc); end
    total++; if (instr_count !== mcount) begin bad++; $display("FAIL count got=%h exp=%h", instr_count, mcount); end
    total++; if (halted !== mhalted) begin bad++; $display("FAIL halted got=%b exp=%b", halted, mhalted); end
    total++; if (iREN !== !mhalted) begin bad++; $display("FAIL post_iren got=%b exp=%b", iREN, !mhalted); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL post_valid got=%b exp=0", instr_valid); end
  endtask

  task automatic set_pc(input logic [31:0] target);
    fetch(0, $urandom);
    exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, target);
  endtask

  task automatic test_reset();
    RST = 1'b1; ihit = 1'b1; iload = 32'hDEAD_BEEF; clear_ctrl(); #1;
    total++; if (iREN !== 1'b0) begin bad++; $display("FAIL rst_iren got=%b exp=0", iREN); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    tick();
    RST = 1'b0; ihit = 1'b0; #1;
    mpc = 32'h0000_0000; mcount = 32'h0000_0000; mhalted = 1'b0;
    total++; if (iaddr !== 32'h0000_0000) begin bad++; $display("FAIL rst_iaddr got=%h exp=0", iaddr); end
    total++; if (imemload !== 32'h0000_0000) begin bad++; $display("FAIL rst_imemload got=%h exp=0", imemload); end
    total++; if (instr_count !== 32'h0000_0000) begin bad++; $display("FAIL rst_count got=%h exp=0", instr_count); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
    total++; if (iREN !== 1'b1) begin bad++; $display("FAIL rst_fetch got=%b exp=1", iREN); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    fetch(2, 32'h2001_0005);
    exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (iaddr !== 32'h0000_0004) begin bad++; $display("FAIL first_iaddr got=%h exp=4", iaddr); end
    total++; if (instr_count !== 32'd1) begin bad++; $display("FAIL first_count got=%h exp=1", instr_count); end
  endtask

  task automatic test_branch();
    set_pc(32'h10); fetch(1, 32'h1000_FFFE);
    exec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (iaddr !== 32'h0000_000C) begin bad++; $display("FAIL beq_taken got=%h exp=c", iaddr); end
    set_pc(32'h10); fetch(0, 32'h1400_FFFE);
    exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (iaddr !== 32'h0000_0014) begin bad++; $display("FAIL bne_not_taken got=%h exp=14", iaddr); end
    set_pc(32'h10); fetch(2, 32'h1000_FFFE);
    exec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (iaddr !== 32'h0000_000C) begin bad++; $display("FAIL beq_bne got=%h exp=c", iaddr); end
  endtask

  task automatic test_jal_jr();
    set_pc(32'h3000_0040); fetch(0, 32'h0C00_0100);
    total++; if (pc_plus4 !== 32'h3000_0044) begin bad++; $display("FAIL jal_link got=%h exp=30000044", pc_plus4); end
    exec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (iaddr !== 32'h3000_0400) begin bad++; $display("FAIL jal_target got=%h exp=30000400", iaddr); end
    fetch(1, 32'h0000_0008);
    exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0123);
    total++; if (iaddr !== 32'h0000_0120) begin bad++; $display("FAIL jr_target got=%h exp=120", iaddr); end
    fetch(0, 32'h0800_0333);
    exec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0123);
    total++; if (iaddr !== 32'h0000_0120) begin bad++; $display("FAIL jr_priority got=%h exp=120", iaddr); end
    set_pc(32'hFFFF_FFFC); fetch(0, 32'h0000_0000);
    exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (iaddr !== 32'h0000_0000) begin bad++; $display("FAIL pc_wrap got=%h exp=0", iaddr); end
  endtask

  task automatic test_halt();
    logic [31:0] frozen_pc, frozen_cnt;
    set_pc(32'h0000_0200); fetch(1, 32'hFC00_0000);
    exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    frozen_pc = mpc; frozen_cnt = mcount;
    for (int i = 0; i < 20; i++) begin
      ihit = 1'b1; iload = $urandom;
      jump = 1'($urandom); jr = 1'($urandom); beq = 1'($urandom); halt = 1'($urandom);
      rdat1 = $urandom;
      tick();
      total++; if (iREN !== 1'b0) begin bad++; $display("FAIL halt_iren got=%b exp=0", iREN); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL halt_valid got=%b exp=0", instr_valid); end
      total++; if (iaddr !== frozen_pc) begin bad++; $display("FAIL halt_pc got=%h exp=%h", iaddr, frozen_pc); end
      total++; if (instr_count !== frozen_cnt) begin bad++; $display("FAIL halt_count got=%h exp=%h", instr_count, frozen_cnt); end
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_sticky got=%b exp=1", halted); end
    end
    do_reset();
    total++; if (iaddr !== 32'h0000_0000) begin bad++; $display("FAIL unhalt_pc got=%h exp=0", iaddr); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL unhalt_halted got=%b exp=0", halted); end
    total++; if (iREN !== 1'b1) begin bad++; $display("FAIL unhalt_iren got=%b exp=1", iREN); end
    fetch(0, 32'h2001_0005);
    exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    fetch(0, 32'h1111_2222);
    exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    ihit = 1'b0; tick();
    RST = 1'b1; ihit = 1'b1; iload = 32'h5555_AAAA; #1;
    total++; if (iREN !== 1'b0) begin bad++; $display("FAIL midrst_iren got=%b exp=0", iREN); end
    tick();
    RST = 1'b0; ihit = 1'b0; #1;
    mpc = 32'h0000_0000; mcount = 32'h0000_0000; mhalted = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", instr_valid); end
    total++; if (imemload !== 32'h0000_0000) begin bad++; $display("FAIL midrst_imemload got=%h exp=0", imemload); end
    total++; if (instr_count !== 32'h0000_0000) begin bad++; $display("FAIL midrst_count got=%h exp=0", instr_count); end
    total++; if (iaddr !== 32'h0000_0000) begin bad++; $display("FAIL midrst_iaddr got=%h exp=0", iaddr); end
    fetch(1, 32'h3333_4444);
    exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if (mhalted) do_reset();
      fetch($urandom_range(0, 3), $urandom);
      exec($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 1'($urandom),
           $urandom_range(0, 24) == 0, $urandom);
    end
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; iload = 32'h0000_0000; clear_ctrl();
    mpc = 32'h0; mcount = 32'h0; mword = 32'h0; mhalted = 1'b0;
    test_reset();
    test_first_fetch();
    test_branch();
    test_jal_jr();
    test_halt();
    test_reset_mid_fetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
